mult_booth_r4_seq: RTL

//   Sequential signed multiplier, radix-4 modified Booth, WIDTH/2 iterations.

---
 rtl/mult_pkg.sv | 50 +++++
 rtl/booth_r4_decode.sv | 39 +++
 rtl/mult_booth_r4_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the radix-4 Booth sequential multiplier:
//     - state_e     : controller states (IDLE / RUN / DONE)
//     - booth_op_e  : recoded Booth operations (ZERO, PM, P2M, NM, N2M)
//     - iter_w()    : iteration counter width for a given operand width
//     - ITER_W      : counter width for the default 32-bit multiplier
//     - booth_op()  : maps a 3-bit multiplier window onto a Booth operation
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,  // add 0
        PM   = 3'd1,  // add +M
        P2M  = 3'd2,  // add +2M
        NM   = 3'd3,  // add -M
        N2M  = 3'd4   // add -2M
    } booth_op_e;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must hold WIDTH/2-1; never let it collapse to zero bits.
    function automatic int iter_w(input int width);
        int w;
        w = $clog2(width / 2);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int ITER_W = iter_w(DEFAULT_WIDTH);

    // Radix-4 recoding of window {q[i+1], q[i], q[i-1]}.
    function automatic booth_op_e booth_op(input logic [2:0] window);
        booth_op_e op;
        case (window)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = N2M;
            3'b101, 3'b110: op = NM;
            default:        op = ZERO;  // 000 and 111
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_decode.sv
// ---------------------------------------------------------------------------
// booth_r4_decode
//   Purely combinational radix-4 Booth window decoder.
//   Ports:
//     window   in  3  multiplier bits {q[i+1], q[i], q[i-1]}
//     op_zero  out 1  addend is zero
//     op_neg   out 1  addend is negated (subtract)
//     op_dbl   out 1  addend is 2M instead of M
// ---------------------------------------------------------------------------
module booth_r4_decode
    import mult_pkg::*;
(
    input  logic [2:0] window,
    output logic       op_zero,
    output logic       op_neg,
    output logic       op_dbl
);

    booth_op_e op;

    always_comb begin
        op      = booth_op(window);
        op_zero = 1'b0;
        op_neg  = 1'b0;
        op_dbl  = 1'b0;
        case (op)
            ZERO:    op_zero = 1'b1;
            PM:      ;
            P2M:     op_dbl  = 1'b1;
            NM:      op_neg  = 1'b1;
            N2M: begin
                op_neg = 1'b1;
                op_dbl = 1'b1;
            end
            default: op_zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/mult_booth_r4_seq.sv
// ---------------------------------------------------------------------------
// mult_booth_r4_seq
//   Sequential signed multiplier, radix-4 modified Booth, WIDTH/2 iterations
//   (one add/sub of 0, +-M, +-2M per cycle). Serves the execute-stage MULT op.
//
//   Optional feature macro: MULT_HI_EN
//     defined   : product_hi port present, carries product[2*WIDTH-1:WIDTH]
//     undefined : product_hi port and its register are absent
//
//   Ports:
//     clock       in   1      rising-edge clock
//     reset       in   1      synchronous, active-high
//     start       in   1      one-cycle request; latches data_a/data_b
//     data_a      in   WIDTH  multiplicand M (two's complement)
//     data_b      in   WIDTH  multiplier Q (two's complement)
//     busy        out  1      high while iterating (RUN)
//     result      out  WIDTH  low WIDTH bits of the product
//     exception   out  1      signed overflow of the WIDTH-bit result
//     result_rdy  out  1      one-cycle pulse (DONE), result/exception valid
//     product_hi  out  WIDTH  upper product half (MULT_HI_EN only)
//     dbg_state   out  2      current controller state (state_e encoding)
//
//   Handshake: start is honoured in every state. In RUN it aborts the
//   current operation (no result_rdy for it); in DONE the finished result is
//   still flagged while the new operands load on the same edge.
// ---------------------------------------------------------------------------
module mult_booth_r4_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
`ifdef MULT_HI_EN
    output logic [WIDTH-1:0] product_hi,
`endif
    output logic [1:0]       dbg_state
);

    // Accumulator is WIDTH+2 bits so +-2M of the most negative M never wraps.
    localparam int AW    = WIDTH + 2;
    localparam int PW    = 2 * WIDTH + 3;
    localparam int CNT_W = iter_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [PW-1:0]      p_q, p_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
`ifdef MULT_HI_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
`endif

    logic               op_zero, op_neg, op_dbl;
    logic [AW-1:0]      m_ext, addend, operand, sum;
    logic [PW-1:0]      p_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     top_bits;
    logic               exc_next;

    booth_r4_decode u_decode (
        .window  (p_q[2:0]),
        .op_zero (op_zero),
        .op_neg  (op_neg),
        .op_dbl  (op_dbl)
    );

    // One Booth step: add/sub onto the upper AW bits, then arithmetic >> 2.
    always_comb begin
        m_ext    = {{2{m_q[WIDTH-1]}}, m_q};
        addend   = op_zero ? '0 : (op_dbl ? (m_ext << 1) : m_ext);
        operand  = op_neg ? ~addend : addend;
        sum      = p_q[PW-1 -: AW] + operand + {{(AW-1){1'b0}}, op_neg};
        p_step   = {{2{sum[AW-1]}}, sum, p_q[WIDTH:2]};
        // After WIDTH/2 steps the product sits just above the guard bit.
        product  = p_step[2*WIDTH:1];
        top_bits = product[2*WIDTH-1:WIDTH-1];
        exc_next = ~((&top_bits) | ~(|top_bits));
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        m_d      = m_q;
        p_d      = p_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MULT_HI_EN
        hi_d     = hi_q;
`endif
        case (state_q)
            IDLE: ;
            RUN: begin
                p_d     = p_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    state_d  = DONE;
                    count_d  = '0;
                    result_d = product[WIDTH-1:0];
                    exc_d    = exc_next;
`ifdef MULT_HI_EN
                    hi_d     = product[2*WIDTH-1:WIDTH];
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A load wins over whatever the current state would do.
        if (start) begin
            state_d = RUN;
            count_d = '0;
            m_d     = data_a;
            p_d     = {{AW{1'b0}}, data_b, 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            m_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULT_HI_EN
            hi_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            m_q      <= m_d;
            p_q      <= p_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef MULT_HI_EN
            hi_q     <= hi_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign result_rdy = (state_q == DONE);
    assign result     = result_q;
    assign exception  = exc_q;
    assign dbg_state  = state_q;
`ifdef MULT_HI_EN
    assign product_hi = hi_q;
`endif

endmodule
